// File: rtl/icache_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : icache_responder_if
// Purpose  : Fetch request/response bundle between the IF stage and the
//            instruction-cache responder.
// Revision : 1.0 - initial release
// ============================================================================
interface icache_responder_if #(
    parameter int ADDR_W = 40,
    parameter int LINE_W = 128
);
    logic              req_valid;
    logic [ADDR_W-1:0] req_vaddr;

    logic              resp_valid;
    logic [LINE_W-1:0] resp_data;
    logic              resp_ex_valid;
    logic [63:0]       resp_ex_cause;
    logic [63:0]       resp_ex_origin;

    modport master (
        output req_valid, req_vaddr,
        input  resp_valid, resp_data, resp_ex_valid, resp_ex_cause, resp_ex_origin
    );

    modport slave (
        input  req_valid, req_vaddr,
        output resp_valid, resp_data, resp_ex_valid, resp_ex_cause, resp_ex_origin
    );
endinterface
`default_nettype wire

// File: rtl/icache_responder.sv
`default_nettype none
// ============================================================================
// Module   : icache_responder
// Purpose  : Direct-mapped flop-based instruction cache with combinational
//            lookup and a single-outstanding line refill port.
// Revision : 1.0 - initial release
// ============================================================================
module icache_responder #(
    parameter int NUM_LINES = 8,
    parameter int ADDR_W    = 40,
    parameter int LINE_W    = 128
) (
    input  wire logic              clk_i,
    input  wire logic              rst_i,
    icache_responder_if.slave      fetch,
    input  wire logic              flush_i,
    output      logic              mem_req_valid_o,
    input  wire logic              mem_req_ready_i,
    output      logic [ADDR_W-1:0] mem_req_addr_o,
    input  wire logic              mem_resp_valid_i,
    input  wire logic [LINE_W-1:0] mem_resp_data_i,
    input  wire logic              mem_resp_error_i
);
    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int LA_W  = ADDR_W - 4;
    localparam int TAG_W = LA_W - IDX_W;
    localparam logic [63:0] CAUSE_MISALIGNED   = 64'd0;
    localparam logic [63:0] CAUSE_ACCESS_FAULT = 64'd1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [LA_W-1:0]   line_addr_q, line_addr_d;
    logic              flush_pend_q, flush_pend_d;
    logic              err_valid_q, err_valid_d;
    logic [LA_W-1:0]   err_line_q, err_line_d;
    logic              valid_q [NUM_LINES];
    logic              valid_d [NUM_LINES];
    logic [TAG_W-1:0]  tag_q   [NUM_LINES];
    logic [TAG_W-1:0]  tag_d   [NUM_LINES];
    logic [LINE_W-1:0] data_q  [NUM_LINES];
    logic [LINE_W-1:0] data_d  [NUM_LINES];

    logic [LA_W-1:0]   req_line;
    logic [IDX_W-1:0]  req_idx;
    logic [TAG_W-1:0]  req_tag;
    logic [IDX_W-1:0]  fill_idx;
    logic [TAG_W-1:0]  fill_tag;
    logic              req_ok, misaligned, err_hit, lookup_hit, miss;

    assign req_line   = fetch.req_vaddr[ADDR_W-1:4];
    assign req_idx    = req_line[IDX_W-1:0];
    assign req_tag    = req_line[LA_W-1:IDX_W];
    assign fill_idx   = line_addr_q[IDX_W-1:0];
    assign fill_tag   = line_addr_q[LA_W-1:IDX_W];
    assign req_ok     = fetch.req_valid && !rst_i;
    assign misaligned = |fetch.req_vaddr[1:0];
    assign err_hit    = err_valid_q && (req_line == err_line_q);
    // A flush in this cycle hides every line, even before the valid bits drop.
    assign lookup_hit = valid_q[req_idx] && (tag_q[req_idx] == req_tag) && !flush_i;
    assign miss       = req_ok && !misaligned && !err_hit && !lookup_hit;

    assign mem_req_valid_o = (state_q == S_REQ) && !rst_i;
    assign mem_req_addr_o  = {line_addr_q, 4'b0000};

    always_comb begin
        fetch.resp_valid     = 1'b0;
        fetch.resp_data      = '0;
        fetch.resp_ex_valid  = 1'b0;
        fetch.resp_ex_cause  = CAUSE_MISALIGNED;
        fetch.resp_ex_origin = 64'(fetch.req_vaddr);
        if (req_ok) begin
            if (misaligned) begin
                fetch.resp_valid    = 1'b1;
                fetch.resp_ex_valid = 1'b1;
            end else if (err_hit) begin
                fetch.resp_valid    = 1'b1;
                fetch.resp_ex_valid = 1'b1;
                fetch.resp_ex_cause = CAUSE_ACCESS_FAULT;
            end else if (lookup_hit) begin
                fetch.resp_valid = 1'b1;
                fetch.resp_data  = data_q[req_idx];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        line_addr_d  = line_addr_q;
        flush_pend_d = flush_pend_q;
        err_valid_d  = err_valid_q;
        err_line_d   = err_line_q;
        valid_d      = valid_q;
        tag_d        = tag_q;
        data_d       = data_q;

        if (req_ok && !misaligned && (req_line != err_line_q)) begin
            err_valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (miss && !flush_i) begin
                    state_d     = S_REQ;
                    line_addr_d = req_line;
                end
            end
            S_REQ: begin
                if (mem_req_ready_i) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_resp_valid_i) begin
                    state_d      = S_IDLE;
                    flush_pend_d = 1'b0;
                    if (mem_resp_error_i) begin
                        err_valid_d = 1'b1;
                        err_line_d  = line_addr_q;
                    end else if (!flush_pend_q) begin
                        valid_d[fill_idx] = 1'b1;
                        tag_d[fill_idx]   = fill_tag;
                        data_d[fill_idx]  = mem_resp_data_i;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Flush wins over a same-edge install or error capture.
        if (flush_i) begin
            for (int i = 0; i < NUM_LINES; i++) begin
                valid_d[i] = 1'b0;
            end
            err_valid_d = 1'b0;
            if ((state_q != S_IDLE) && !((state_q == S_WAIT) && mem_resp_valid_i)) begin
                flush_pend_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            line_addr_q  <= '0;
            flush_pend_q <= 1'b0;
            err_valid_q  <= 1'b0;
            err_line_q   <= '0;
            for (int i = 0; i < NUM_LINES; i++) begin
                valid_q[i] <= 1'b0;
            end
        end else begin
            state_q      <= state_d;
            line_addr_q  <= line_addr_d;
            flush_pend_q <= flush_pend_d;
            err_valid_q  <= err_valid_d;
            err_line_q   <= err_line_d;
            valid_q      <= valid_d;
        end
    end

    always_ff @(posedge clk_i) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end
endmodule
`default_nettype wire

// File: doc/icache_responder.md
Name: icache_responder

Overview:
- CPU-facing instruction-cache responder: the responder end of the fetch interface driven by the IF stage.
- Takes `req_cpu_icache_t` requests (valid, 40-bit vaddr) and returns `req_icache_cpu_t` responses (valid, 128-bit line, exception).
- Small direct-mapped line store held in flops; misses are refilled through a single-outstanding memory port.
- Sits between `if_stage` and the L2/memory refill interface. No translation (bare mode), so no page faults are generated.

Parameters:
- NUM_LINES, 8, number of 128-bit lines; power of 2, minimum 2.
- ADDR_W, 40, virtual/physical fetch address width.
- LINE_W, 128, line width (four 32-bit instructions).

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- req_cpu_icache_i  in  req_cpu_icache_t  fetch request: .valid, .vaddr[39:0]; IF holds it stable while stalled.
- req_icache_cpu_o  out  req_icache_cpu_t  response: .valid, .data[127:0], .ex.valid, .ex.cause, .ex.origin.
- flush_i  in  1  fence.i: invalidate all lines.
- mem_req_valid_o  out  1  refill request valid.
- mem_req_ready_i  in  1  memory accepts request.
- mem_req_addr_o  out  ADDR_W  refill line address; bits [3:0] always 0.
- mem_resp_valid_i  in  1  refill data valid, one-cycle pulse; always accepted.
- mem_resp_data_i  in  LINE_W  refill line.
- mem_resp_error_i  in  1  bus error for this refill.

Behaviour:
- Address split: offset = vaddr[3:0]; index = vaddr[4+log2(NUM_LINES)-1:4]; tag = vaddr[39:4+log2(NUM_LINES)].
- Storage: per line a valid bit, tag, and data. Lookup is combinational, so a hit responds in the same cycle as the request.
- Error record: one entry (err_valid, err_line_addr).
- Response priority, evaluated combinationally every cycle:
  1. rst_i=1 or req.valid=0 → .valid=0, .ex.valid=0.
  2. vaddr[1:0]≠0 → .valid=1, .ex.valid=1, .ex.cause=INSTR_ADDR_MISALIGNED; no refill.
  3. err_valid and vaddr[39:4]==err_line_addr[39:4] → .valid=1, .ex.valid=1, .ex.cause=INSTR_ACCESS_FAULT.
  4. Tag hit with valid bit set and flush_i=0 → .valid=1, .data=line, .ex.valid=0.
  5. Otherwise (miss) → .valid=0.
  - .ex.origin = vaddr zero-extended to 64 bits in all cases.
  - .ex.cause = INSTR_ADDR_MISALIGNED whenever .ex.valid=0.
- FSM states: IDLE, REQ, WAIT. Reset value is IDLE.
  - IDLE → REQ on a miss with flush_i=0. Latch the line address {vaddr[39:4], 4'b0}.
  - REQ: mem_req_valid_o=1 with mem_req_addr_o held stable. Advance to WAIT when mem_req_ready_i=1.
  - WAIT: on mem_resp_valid_i, return to IDLE.
    - If error=0 and flush_pending=0: write data, tag and valid bit on that edge.
    - If error=1: no install; set the error record to the latched address.
    - Clear flush_pending.
- Miss latency: request at cycle 0 → mem_req_valid_o at cycle 1 → data at cycle T → hit response at T+1.
- Address changes mid-refill (jump): the refill still completes and installs; the new address is looked up afterwards.
- Error record clears when:
  - a valid aligned request targets a different line, or
  - flush_i=1, or
  - reset.
- flush_i:
  - Clears all valid bits and the error record on the same edge.
  - Lookups in the flush cycle report a miss.
  - Flush in REQ/WAIT sets flush_pending. The outstanding refill is still driven to completion and drained, and its data is discarded.
- Reset (including mid-refill):
  - All valid bits=0, state=IDLE, mem_req_valid_o=0, err_valid=0, flush_pending=0.
  - A memory response arriving after reset is ignored in IDLE.
- Only one refill outstanding. mem_req_valid_o never deasserts before ready. mem_resp_valid_i outside WAIT is ignored.

Test Plan:
- Cold miss: after reset, req vaddr=0x200, memory ready immediately, data returned 3 cycles after acceptance.
  - Expect mem_req_addr_o=0x200 asserted at cycle 1; valid=0 until install.
  - Expect valid=1 with data = the returned line on the cycle after mem_resp_valid_i.
- Hit sequence: after installing line 0x200, requests 0x204, 0x208, 0x20C.
  - Expect same-cycle valid=1, identical data, no memory traffic.
- Conflict eviction (NUM_LINES=8): install 0x200, then request 0x280.
  - Expect a miss and refill to 0x280; a subsequent request to 0x200 misses again.
- Misaligned: req vaddr=0x202.
  - Expect same-cycle valid=1, ex.valid=1, cause=INSTR_ADDR_MISALIGNED, origin=0x202, mem_req_valid_o stays 0.
- Bus error: refill of 0x300 returns error=1.
  - Expect ex.valid=1, cause=INSTR_ACCESS_FAULT for 0x300; line not installed.
  - Request 0x400 clears the record; a later 0x300 request re-refills.
- Flush/reset during refill:
  - flush_i in WAIT → data discarded, next lookup of the same line misses.
  - mem_req_ready_i held low 5 cycles → addr stable.
  - rst_i in WAIT → IDLE, late response ignored, all lookups miss.
